lsu_dbus: RTL and testbench

Load/store unit that consumes the EX-stage memory controls (load/store strobes, funct3 width select, ALU-computed address, store data) and acts as the initiator on the data-memory bus. It stalls the pipeline for the duration of each access. It generates byte enables and lane-replicated write data, and returns aligned, sign- or zero-extended load data to writeback. Misaligned, illegal and bus-error accesses are flagged as one-cycle faults.

---
 rtl/loopyV_data_types.sv | 61 ++++++
 rtl/lsu_load_align.sv | 32 +++
 rtl/lsu_dbus.sv | 135 +++++++++++++
 tb/tb_lsu_dbus.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loopyV_data_types.sv
// Shared pipeline data types.
// Holds the load/store width encodings (funct3) and the LSU bus FSM state type,
// plus small helpers for byte-lane generation and access legality.
package loopyV_data_types;

   localparam logic [2:0] FUNCT3_BYTE   = 3'b000;
   localparam logic [2:0] FUNCT3_HALF   = 3'b001;
   localparam logic [2:0] FUNCT3_WORD   = 3'b010;
   localparam logic [2:0] FUNCT3_BYTE_U = 3'b100;
   localparam logic [2:0] FUNCT3_HALF_U = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } lsuStateType;

   // Unsigned widths only exist for loads.
   function automatic logic lsu_illegal(input logic [2:0] funct3, input logic is_store);
      logic ill;
      case (funct3)
         FUNCT3_BYTE, FUNCT3_HALF, FUNCT3_WORD: ill = 1'b0;
         FUNCT3_BYTE_U, FUNCT3_HALF_U:          ill = is_store;
         default:                               ill = 1'b1;
      endcase
      return ill;
   endfunction

   function automatic logic lsu_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
      logic mis;
      case (funct3)
         FUNCT3_HALF, FUNCT3_HALF_U: mis = offset[0];
         FUNCT3_WORD:                mis = (offset != 2'b00);
         default:                    mis = 1'b0;
      endcase
      return mis;
   endfunction

   function automatic logic [3:0] lsu_byte_enable(input logic [2:0] funct3, input logic [1:0] offset);
      logic [3:0] be;
      case (funct3)
         FUNCT3_BYTE, FUNCT3_BYTE_U: be = 4'b0001 << offset;
         FUNCT3_HALF, FUNCT3_HALF_U: be = offset[1] ? 4'b1100 : 4'b0011;
         default:                    be = 4'b1111;
      endcase
      return be;
   endfunction

   // Data is replicated across lanes so the byte enables alone select the target.
   function automatic logic [31:0] lsu_store_lanes(input logic [2:0] funct3, input logic [31:0] sd);
      logic [31:0] wd;
      case (funct3)
         FUNCT3_BYTE, FUNCT3_BYTE_U: wd = {4{sd[7:0]}};
         FUNCT3_HALF, FUNCT3_HALF_U: wd = {2{sd[15:0]}};
         default:                    wd = sd;
      endcase
      return wd;
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data formatter.
// Shifts the addressed byte/halfword of a bus word down to bit 0 and sign- or
// zero-extends it according to funct3. Purely combinational.
//   rdata  in  32  raw word from the data bus
//   offset in  2   byte offset within the word
//   funct3 in  3   load width / signedness
//   data   out 32  formatted load result
module lsu_load_align
   import loopyV_data_types::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);

   logic [31:0] shifted;

   assign shifted = rdata >> {offset, 3'b000};

   always_comb begin
      data = shifted;
      case (funct3)
         FUNCT3_BYTE:   data = {{24{shifted[7]}}, shifted[7:0]};
         FUNCT3_HALF:   data = {{16{shifted[15]}}, shifted[15:0]};
         FUNCT3_BYTE_U: data = {24'h0, shifted[7:0]};
         FUNCT3_HALF_U: data = {16'h0, shifted[15:0]};
         default:       data = shifted;   // word accesses are always at offset 0
      endcase
   end

endmodule

// File: rtl/lsu_dbus.sv
// Load/store unit, data-bus initiator.
// Takes EX-stage memory controls, runs one bus transaction at a time while
// stalling the pipeline, and returns formatted load data or a fault strobe.
//   clk, arst                    clock, async active-high reset
//   loadSignalEX/storeSignalEX   access request from EX
//   loadStoreByteSelectEX        funct3 width select
//   addressEX, storeDataEX       byte address and rs2 data
//   stallLSU                     holds IF/ID/EX during an access
//   loadDataValid, loadData      one-cycle load result
//   misalignedFault, busFault    one-cycle fault strobes
//   dbus*                        data-memory bus (req/gnt, rvalid/rdata/err)
//
// state | meaning
// IDLE  | no access in flight; legal EX access starts one, bad one faults
// REQ   | dbusReq held until dbusGnt
// WAIT  | granted, waiting for dbusRvalid
// DONE  | response registered; strobes out, stall released
module lsu_dbus
   import loopyV_data_types::*;
(
   input  logic        clk,
   input  logic        arst,
   input  logic        loadSignalEX,
   input  logic        storeSignalEX,
   input  logic [2:0]  loadStoreByteSelectEX,
   input  logic [31:0] addressEX,
   input  logic [31:0] storeDataEX,
   output logic        stallLSU,
   output logic        loadDataValid,
   output logic [31:0] loadData,
   output logic        misalignedFault,
   output logic        busFault,
   output logic        dbusReq,
   output logic [31:0] dbusAddr,
   output logic        dbusWe,
   output logic [3:0]  dbusBe,
   output logic [31:0] dbusWdata,
   input  logic        dbusGnt,
   input  logic        dbusRvalid,
   input  logic [31:0] dbusRdata,
   input  logic        dbusErr
);

   lsuStateType state_q, state_d;

   logic [2:0]  funct3_q;
   logic [1:0]  offset_q;
   logic        resp_err_q;
   logic        resp_load_q;
   logic [31:0] aligned_data;

   logic access, bad_access, legal_access, start;

   // Gating with arst keeps every output low while reset is held, even if
   // EX still presents an access.
   assign access       = (loadSignalEX | storeSignalEX) & ~arst;
   assign bad_access   = lsu_illegal(loadStoreByteSelectEX, storeSignalEX)
                       | lsu_misaligned(loadStoreByteSelectEX, addressEX[1:0]);
   assign legal_access = access & ~bad_access;

   lsu_load_align u_align (
      .rdata  (dbusRdata),
      .offset (offset_q),
      .funct3 (funct3_q),
      .data   (aligned_data)
   );

   always_comb begin
      state_d         = state_q;
      start           = 1'b0;
      stallLSU        = 1'b0;
      dbusReq         = 1'b0;
      misalignedFault = 1'b0;
      loadDataValid   = 1'b0;
      busFault        = 1'b0;
      case (state_q)
         IDLE: begin
            if (legal_access) begin
               start    = 1'b1;
               stallLSU = 1'b1;
               state_d  = REQ;
            end else if (access) begin
               misalignedFault = 1'b1;
            end
         end
         REQ: begin
            dbusReq  = 1'b1;
            stallLSU = 1'b1;
            if (dbusGnt) state_d = WAIT;
         end
         WAIT: begin
            stallLSU = 1'b1;
            if (dbusRvalid) state_d = DONE;
         end
         DONE: begin
            // EX still holds the finished instruction this cycle; do not restart.
            loadDataValid = resp_load_q & ~resp_err_q;
            busFault      = resp_err_q;
            state_d       = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q     <= IDLE;
         funct3_q    <= 3'b000;
         offset_q    <= 2'b00;
         dbusAddr    <= 32'h0;
         dbusWe      <= 1'b0;
         dbusBe      <= 4'h0;
         dbusWdata   <= 32'h0;
         resp_err_q  <= 1'b0;
         resp_load_q <= 1'b0;
         loadData    <= 32'h0;
      end else begin
         state_q <= state_d;
         if (start) begin
            funct3_q  <= loadStoreByteSelectEX;
            offset_q  <= addressEX[1:0];
            dbusAddr  <= {addressEX[31:2], 2'b00};
            dbusWe    <= storeSignalEX;
            dbusBe    <= lsu_byte_enable(loadStoreByteSelectEX, addressEX[1:0]);
            dbusWdata <= lsu_store_lanes(loadStoreByteSelectEX, storeDataEX);
         end
         if (state_q == WAIT && dbusRvalid) begin
            resp_err_q  <= dbusErr;
            resp_load_q <= ~dbusWe;
            loadData    <= aligned_data;
         end
      end
   end

endmodule

// File: tb/tb_lsu_dbus.sv
module tb_lsu_dbus;
   import loopyV_data_types::*;

   logic        clk = 1'b0;
   logic        arst;
   logic        loadSignalEX, storeSignalEX;
   logic [2:0]  loadStoreByteSelectEX;
   logic [31:0] addressEX, storeDataEX;
   logic        stallLSU, loadDataValid, misalignedFault, busFault;
   logic [31:0] loadData;
   logic        dbusReq, dbusWe;
   logic [31:0] dbusAddr, dbusWdata;
   logic [3:0]  dbusBe;
   logic        dbusGnt, dbusRvalid, dbusErr;
   logic [31:0] dbusRdata;

   lsu_dbus dut (
      .clk(clk), .arst(arst),
      .loadSignalEX(loadSignalEX), .storeSignalEX(storeSignalEX),
      .loadStoreByteSelectEX(loadStoreByteSelectEX),
      .addressEX(addressEX), .storeDataEX(storeDataEX),
      .stallLSU(stallLSU), .loadDataValid(loadDataValid), .loadData(loadData),
      .misalignedFault(misalignedFault), .busFault(busFault),
      .dbusReq(dbusReq), .dbusAddr(dbusAddr), .dbusWe(dbusWe), .dbusBe(dbusBe),
      .dbusWdata(dbusWdata), .dbusGnt(dbusGnt), .dbusRvalid(dbusRvalid),
      .dbusRdata(dbusRdata), .dbusErr(dbusErr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
      bit          chk_wdata;
   } req_t;

   typedef struct {
      logic        valid;
      logic        fault;
      logic [31:0] data;
   } resp_t;

   req_t  req_q[$];
   resp_t resp_q[$];
   int    flt_q[$];
   int    checks = 0;
   int    errors = 0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic exp_req(input logic [31:0] a, input logic we, input logic [3:0] be,
                          input logic [31:0] wd, input bit chk);
      req_t r;
      r.addr = a; r.we = we; r.be = be; r.wdata = wd; r.chk_wdata = chk;
      req_q.push_back(r);
   endtask

   task automatic exp_resp(input logic v, input logic f, input logic [31:0] d);
      resp_t r;
      r.valid = v; r.fault = f; r.data = d;
      resp_q.push_back(r);
   endtask

   // Scoreboard monitor: compares whenever the DUT presents a request,
   // a completion (stall falling) or a misalignment strobe.
   initial begin : monitor
      logic prev_stall, prev_req;
      bit   active;
      req_t  cur;
      resp_t rsp;
      prev_stall = 1'b0; prev_req = 1'b0; active = 0;
      forever begin
         @(negedge clk);
         if (arst) begin
            prev_stall = 1'b0; prev_req = 1'b0; active = 0;
         end else begin
            if (dbusReq && !prev_req) begin
               if (req_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_req actual=%h expected=none", dbusAddr);
               end else begin
                  cur = req_q.pop_front();
                  active = 1;
               end
            end
            if (active && stallLSU) begin
               check32("req_addr", dbusAddr, cur.addr);
               check32("req_we", {31'h0, dbusWe}, {31'h0, cur.we});
               check32("req_be", {28'h0, dbusBe}, {28'h0, cur.be});
               if (cur.chk_wdata) check32("req_wdata", dbusWdata, cur.wdata);
            end
            if (prev_stall && !stallLSU) begin
               active = 0;
               if (resp_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_done actual=valid%0d expected=none", loadDataValid);
               end else begin
                  rsp = resp_q.pop_front();
                  check32("done_valid", {31'h0, loadDataValid}, {31'h0, rsp.valid});
                  check32("done_busfault", {31'h0, busFault}, {31'h0, rsp.fault});
                  if (rsp.valid) check32("done_data", loadData, rsp.data);
               end
            end else if (loadDataValid || busFault) begin
               checks++; errors++;
               $display("FAIL unexpected_strobe actual=valid%0d/bus%0d expected=0", loadDataValid, busFault);
            end
            if (misalignedFault) begin
               if (flt_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_misaligned actual=1 expected=0");
               end else begin
                  void'(flt_q.pop_front());
                  check32("fault_stall", {31'h0, stallLSU}, 32'h0);
                  check32("fault_req", {31'h0, dbusReq}, 32'h0);
               end
            end
            prev_stall = stallLSU;
            prev_req   = dbusReq;
         end
      end
   end

   task automatic run_access(input bit ld, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] sd, input int gnt_dly, input int rv_dly,
                             input logic [31:0] rdata, input bit err, input int exp_stall,
                             input string name);
      int stall_cnt = 0, req_cnt = 0, wait_cnt = 0;
      bit granted = 0, done = 0;
      @(posedge clk); #1;
      loadSignalEX = ld; storeSignalEX = !ld;
      loadStoreByteSelectEX = f3; addressEX = addr; storeDataEX = sd;
      for (int cyc = 0; cyc < 60 && !done; cyc++) begin
         @(negedge clk);
         if (granted && !stallLSU) begin
            done = 1;
            dbusGnt = 0; dbusRvalid = 0; dbusErr = 0;
         end else begin
            if (stallLSU) stall_cnt++;
            dbusGnt = 0; dbusRvalid = 0; dbusErr = 0;
            if (dbusReq) begin
               if (req_cnt == gnt_dly) begin dbusGnt = 1; granted = 1; end
               req_cnt++;
            end else if (granted) begin
               if (wait_cnt == rv_dly) begin
                  dbusRvalid = 1; dbusRdata = rdata; dbusErr = err;
               end
               wait_cnt++;
            end
         end
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL %s_timeout actual=stalled expected=done", name);
      end
      @(posedge clk); #1;
      loadSignalEX = 0; storeSignalEX = 0;
      check32({name, "_stall_cycles"}, stall_cnt, exp_stall);
   endtask

   task automatic run_illegal(input bit ld, input logic [2:0] f3, input logic [31:0] addr,
                              input string name);
      flt_q.push_back(1);
      @(posedge clk); #1;
      loadSignalEX = ld; storeSignalEX = !ld;
      loadStoreByteSelectEX = f3; addressEX = addr; storeDataEX = 32'hFFFF_FFFF;
      @(negedge clk);
      check32({name, "_fault"}, {31'h0, misalignedFault}, 32'h1);
      @(posedge clk); #1;
      loadSignalEX = 0; storeSignalEX = 0;
      @(negedge clk);
      check32({name, "_fault_gone"}, {31'h0, misalignedFault}, 32'h0);
      check32({name, "_no_req"}, {31'h0, dbusReq}, 32'h0);
      check32({name, "_no_stall"}, {31'h0, stallLSU}, 32'h0);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      arst = 1;
      loadSignalEX = 0; storeSignalEX = 0; loadStoreByteSelectEX = 3'b000;
      addressEX = 0; storeDataEX = 0;
      dbusGnt = 0; dbusRvalid = 0; dbusErr = 0; dbusRdata = 0;
      repeat (2) @(negedge clk);
      check32("rst_req", {31'h0, dbusReq}, 32'h0);
      check32("rst_stall", {31'h0, stallLSU}, 32'h0);
      check32("rst_loaddata", loadData, 32'h0);
      check32("rst_addr", dbusAddr, 32'h0);
      check32("rst_strobes", {29'h0, loadDataValid, misalignedFault, busFault}, 32'h0);
      arst = 0;

      // LW 0x100, zero-wait bus
      exp_req(32'h100, 0, 4'b1111, 32'h0, 0);
      exp_resp(1, 0, 32'hDEADBEEF);
      run_access(1, FUNCT3_WORD, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 0, 3, "lw");

      // LB / LBU at 0x103
      exp_req(32'h100, 0, 4'b1000, 32'h0, 0);
      exp_resp(1, 0, 32'hFFFFFF80);
      run_access(1, FUNCT3_BYTE, 32'h103, 32'h0, 0, 0, 32'h80FF0000, 0, 3, "lb");
      exp_req(32'h100, 0, 4'b1000, 32'h0, 0);
      exp_resp(1, 0, 32'h00000080);
      run_access(1, FUNCT3_BYTE_U, 32'h103, 32'h0, 0, 0, 32'h80FF0000, 0, 3, "lbu");

      // LH / LHU at 0x12, upper halfword
      exp_req(32'h10, 0, 4'b1100, 32'h0, 0);
      exp_resp(1, 0, 32'hFFFF8001);
      run_access(1, FUNCT3_HALF, 32'h12, 32'h0, 0, 0, 32'h80017F00, 0, 3, "lh");
      exp_req(32'h10, 0, 4'b1100, 32'h0, 0);
      exp_resp(1, 0, 32'h00008001);
      run_access(1, FUNCT3_HALF_U, 32'h12, 32'h0, 0, 0, 32'h80017F00, 0, 3, "lhu");

      // LB positive byte at lane 1
      exp_req(32'h0, 0, 4'b0010, 32'h0, 0);
      exp_resp(1, 0, 32'h0000007F);
      run_access(1, FUNCT3_BYTE, 32'h1, 32'h0, 0, 0, 32'h00007F00, 0, 3, "lb_pos");

      // Stores
      exp_req(32'h200, 1, 4'b1100, 32'hABCDABCD, 1);
      exp_resp(0, 0, 32'h0);
      run_access(0, FUNCT3_HALF, 32'h202, 32'h1234ABCD, 0, 0, 32'h0, 0, 3, "sh");
      exp_req(32'h4, 1, 4'b0010, 32'h5A5A5A5A, 1);
      exp_resp(0, 0, 32'h0);
      run_access(0, FUNCT3_BYTE, 32'h5, 32'h0000005A, 0, 0, 32'h0, 0, 3, "sb");
      exp_req(32'h8, 1, 4'b1111, 32'hCAFEF00D, 1);
      exp_resp(0, 1, 32'h0);
      run_access(0, FUNCT3_WORD, 32'h8, 32'hCAFEF00D, 1, 0, 32'h0, 1, 4, "sw_err");

      // Illegal / misaligned
      run_illegal(1, FUNCT3_WORD, 32'h101, "lw_mis");
      run_illegal(0, FUNCT3_HALF_U, 32'h0, "sHU_ill");
      run_illegal(1, FUNCT3_HALF, 32'h3, "lh_mis");
      run_illegal(1, 3'b011, 32'h0, "f3_011");
      run_illegal(0, 3'b110, 32'h0, "f3_110");

      // LH at 0 with slow grant, slow response and bus error
      exp_req(32'h0, 0, 4'b0011, 32'h0, 0);
      exp_resp(0, 1, 32'h0);
      run_access(1, FUNCT3_HALF, 32'h0, 32'h0, 3, 2, 32'h12345678, 1, 8, "lh_err");

      // Reset during WAIT
      exp_req(32'h300, 0, 4'b1111, 32'h0, 0);
      @(posedge clk); #1;
      loadSignalEX = 1; storeSignalEX = 0; loadStoreByteSelectEX = FUNCT3_WORD; addressEX = 32'h300;
      @(negedge clk);
      @(negedge clk);
      check32("rstw_req_before", {31'h0, dbusReq}, 32'h1);
      dbusGnt = 1;
      @(negedge clk);
      dbusGnt = 0;
      check32("rstw_stall_before", {31'h0, stallLSU}, 32'h1);
      #2 arst = 1;
      #1;
      check32("rstw_req", {31'h0, dbusReq}, 32'h0);
      check32("rstw_stall", {31'h0, stallLSU}, 32'h0);
      check32("rstw_addr", dbusAddr, 32'h0);
      loadSignalEX = 0;
      @(negedge clk);
      #2 arst = 0;
      @(negedge clk);
      dbusRvalid = 1; dbusRdata = 32'h11223344; dbusErr = 0;
      @(negedge clk);
      dbusRvalid = 0;
      check32("late_rvalid_valid", {31'h0, loadDataValid}, 32'h0);
      check32("late_rvalid_stall", {31'h0, stallLSU}, 32'h0);
      check32("late_rvalid_data", loadData, 32'h0);

      exp_req(32'h300, 0, 4'b1111, 32'h0, 0);
      exp_resp(1, 0, 32'h0BADF00D);
      run_access(1, FUNCT3_WORD, 32'h300, 32'h0, 0, 0, 32'h0BADF00D, 0, 3, "lw_after_rst");

      repeat (3) @(negedge clk);
      check32("req_q_drained", req_q.size(), 32'h0);
      check32("resp_q_drained", resp_q.size(), 32'h0);
      check32("flt_q_drained", flt_q.size(), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
